// File: rtl/sccb_control.sv
// Write-only SCCB master: on a start edge, streams a fixed table of {reg, val}
// writes to the camera, pausing after the soft-reset entry.
module sccb_control #(
  parameter int unsigned CLK_FREQ_HZ       = 50_000_000,
  parameter int unsigned SCL_FREQ_HZ       = 100_000,
  parameter logic [7:0]  DEV_ADDR          = 8'h42,
  parameter int unsigned RESET_WAIT_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start_fsm,
  output logic scl,
  inout  wire  sda
);

  localparam int unsigned Q        = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ);
  localparam int unsigned QW       = (Q > 1) ? $clog2(Q) : 1;
  localparam int unsigned WW       = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
  localparam logic [QW-1:0] QLast  = QW'(Q - 1);
  localparam logic [WW-1:0] WLast  = WW'(RESET_WAIT_CYCLES - 1);
  localparam logic [4:0] LastBit   = 5'd26;
  localparam logic [2:0] LastIdx   = 3'd7;

  typedef enum logic [2:0] {StIdle, StStart, StBits, StStop, StGap, StDelay} state_e;

  state_e          r_state, w_state_nxt;
  logic [QW-1:0]   r_qcnt, w_qcnt_nxt;
  logic [1:0]      r_qtr, w_qtr_nxt;
  logic [4:0]      r_bit, w_bit_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [WW-1:0]   r_wait, w_wait_nxt;
  logic            r_sda_low, w_sda_low_nxt;
  logic            r_start_q, r_start_p;
  logic            w_rise, w_tick, w_bit_val, w_sda_low;
  logic [7:0]      w_reg, w_val;
  logic [26:0]     w_frame;

  assign w_rise = r_start_q & ~r_start_p;
  assign w_tick = (r_qcnt == QLast);

  // Configuration ROM, indexed by the current table entry.
  always_comb begin
    w_reg = 8'h12;
    w_val = 8'h80;
    unique case (r_idx)
      3'd0: begin w_reg = 8'h12; w_val = 8'h80; end
      3'd1: begin w_reg = 8'h12; w_val = 8'h04; end
      3'd2: begin w_reg = 8'h40; w_val = 8'hD0; end
      3'd3: begin w_reg = 8'h11; w_val = 8'h01; end
      3'd4: begin w_reg = 8'h0C; w_val = 8'h00; end
      3'd5: begin w_reg = 8'h3E; w_val = 8'h00; end
      3'd6: begin w_reg = 8'h8C; w_val = 8'h00; end
      3'd7: begin w_reg = 8'h3A; w_val = 8'h04; end
      default: ;
    endcase
  end

  // Trailing 1 after each byte releases sda for the don't-care 9th bit.
  assign w_frame   = {DEV_ADDR, 1'b1, w_reg, 1'b1, w_val, 1'b1};
  assign w_bit_val = w_frame[LastBit - r_bit];

  // State register plus all counters; the start input is registered for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_qcnt    <= '0;
      r_qtr     <= '0;
      r_bit     <= '0;
      r_idx     <= '0;
      r_wait    <= '0;
      r_sda_low <= 1'b0;
      r_start_q <= 1'b0;
      r_start_p <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_qcnt    <= w_qcnt_nxt;
      r_qtr     <= w_qtr_nxt;
      r_bit     <= w_bit_nxt;
      r_idx     <= w_idx_nxt;
      r_wait    <= w_wait_nxt;
      r_sda_low <= w_sda_low_nxt;
      r_start_q <= start_fsm;
      r_start_p <= r_start_q;
    end
  end

  // Next-state logic; quarter timer is parked at zero while the bus is idle.
  always_comb begin
    w_state_nxt   = r_state;
    w_qtr_nxt     = r_qtr;
    w_bit_nxt     = r_bit;
    w_idx_nxt     = r_idx;
    w_wait_nxt    = r_wait;
    w_sda_low_nxt = r_sda_low;
    if (r_state == StIdle || r_state == StDelay || w_tick) begin
      w_qcnt_nxt = '0;
    end else begin
      w_qcnt_nxt = r_qcnt + 1'b1;
    end
    case (r_state)
      StIdle: begin
        if (w_rise) begin
          w_state_nxt = StStart;
          w_idx_nxt   = '0;
          w_qtr_nxt   = '0;
        end
      end
      StStart: begin
        w_sda_low_nxt = 1'b1;
        if (w_tick) begin
          w_qtr_nxt = r_qtr + 1'b1;
          if (r_qtr == 2'd1) begin
            w_state_nxt = StBits;
            w_qtr_nxt   = '0;
            w_bit_nxt   = '0;
          end
        end
      end
      StBits: begin
        if (w_tick) begin
          w_qtr_nxt = r_qtr + 1'b1;
          if (r_qtr == 2'd0) w_sda_low_nxt = ~w_bit_val;
          if (r_qtr == 2'd3) begin
            if (r_bit == LastBit) w_state_nxt = StStop;
            else                  w_bit_nxt   = r_bit + 1'b1;
          end
        end
      end
      StStop: begin
        if (w_tick) begin
          w_qtr_nxt = r_qtr + 1'b1;
          if (r_qtr == 2'd3) w_state_nxt = StGap;
        end
      end
      StGap: begin
        if (w_tick) begin
          w_qtr_nxt = r_qtr + 1'b1;
          if (r_qtr == 2'd3) begin
            if (r_idx == 3'd0) begin
              w_state_nxt = StDelay;
              w_wait_nxt  = '0;
            end else if (r_idx == LastIdx) begin
              w_state_nxt = StIdle;
            end else begin
              w_idx_nxt   = r_idx + 1'b1;
              w_state_nxt = StStart;
            end
          end
        end
      end
      StDelay: begin
        if (r_wait == WLast) begin
          w_wait_nxt  = '0;
          w_idx_nxt   = 3'd1;
          w_qtr_nxt   = '0;
          w_state_nxt = StStart;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Bus outputs decoded from state so reset releases the bus immediately.
  always_comb begin
    scl       = 1'b1;
    w_sda_low = 1'b0;
    case (r_state)
      StStart: w_sda_low = 1'b1;
      StBits: begin
        scl       = r_qtr[1];
        w_sda_low = r_sda_low;
      end
      StStop: begin
        scl       = r_qtr[1];
        w_sda_low = 1'b1;
      end
      default: ;
    endcase
  end

  assign sda = w_sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sccb_control.sv
// Randomized bench for sccb_control: an SCCB bus monitor decodes frames and
// the results are compared against the configuration table and frame timing.
module tb_sccb_control;

  localparam int unsigned ClkHz  = 800_000;
  localparam int unsigned SclHz  = 100_000;
  localparam int          Q      = 2;
  localparam int          W      = 300;
  localparam int          NFr    = 8;
  localparam int          FrameQ = 118;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_fsm = 1'b0;
  logic scl;
  wire  sda;

  pullup (sda);

  sccb_control #(
    .CLK_FREQ_HZ      (ClkHz),
    .SCL_FREQ_HZ      (SclHz),
    .DEV_ADDR         (8'h42),
    .RESET_WAIT_CYCLES(W)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start_fsm(start_fsm),
    .scl      (scl),
    .sda      (sda)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_reg [NFr] = '{8'h12, 8'h12, 8'h40, 8'h11, 8'h0C, 8'h3E, 8'h8C, 8'h3A};
  logic [7:0] exp_val [NFr] = '{8'h80, 8'h04, 8'hD0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04};

  // Monitor state
  int         cyc = 0;
  int         q_start[$];
  int         q_stop[$];
  logic [7:0] q_byte[$];
  logic       q_ack[$];
  int         n_lows = 0;
  int         n_low_bad = 0;
  int         n_edges = 0;
  int         nb = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q_start.delete();
    q_stop.delete();
    q_byte.delete();
    q_ack.delete();
    n_lows    = 0;
    n_low_bad = 0;
    nb        = 0;
  endtask

  // Expected START offset of frame k from frame 0, from the write length and reset pause.
  function automatic int exp_start(input int k);
    return k * FrameQ * Q + ((k > 0) ? W : 0);
  endfunction

  // SCCB monitor sampling the bus on the falling clock edge.
  initial begin : monitor
    logic       p_scl;
    logic       p_sda;
    logic       c_scl;
    logic       c_sda;
    int         t_fall;
    logic [8:0] sh;
    p_scl  = 1'b1;
    p_sda  = 1'b1;
    t_fall = 0;
    sh     = '0;
    forever begin
      @(negedge clk);
      cyc++;
      c_scl = scl;
      c_sda = sda;
      if (c_scl !== p_scl || c_sda !== p_sda) n_edges++;
      if (p_scl && c_scl && p_sda && !c_sda) begin
        q_start.push_back(cyc);
        nb = 0;
      end
      if (p_scl && c_scl && !p_sda && c_sda) q_stop.push_back(cyc);
      if (p_scl && !c_scl) t_fall = cyc;
      if (!p_scl && c_scl) begin
        n_lows++;
        if (cyc - t_fall != 2 * Q) n_low_bad++;
        sh = {sh[7:0], c_sda};
        nb++;
        if (nb == 9) begin
          q_byte.push_back(sh[8:1]);
          q_ack.push_back(sh[0]);
          nb = 0;
        end
      end
      p_scl = c_scl;
      p_sda = c_sda;
    end
  end

  // Waits for a full sequence, lets the bus sit idle, then checks everything captured.
  task automatic run_seq(input string tag, input int t_set);
    int budget;
    int e0;
    int d;
    int acks;
    budget = NFr * FrameQ * Q + W + 500;
    while (q_stop.size() < NFr && budget > 0) begin
      tick(1);
      budget--;
    end
    check_eq({tag, "_done_in_time"}, (budget > 0) ? 1 : 0, 1);
    e0 = n_edges;
    tick(3 * FrameQ * Q);
    check_eq({tag, "_idle_edges"}, n_edges - e0, 0);
    check_eq({tag, "_idle_scl"}, int'(scl), 1);
    check_eq({tag, "_idle_sda"}, int'(sda), 1);
    check_eq({tag, "_n_start"}, q_start.size(), NFr);
    check_eq({tag, "_n_stop"}, q_stop.size(), NFr);
    check_eq({tag, "_n_bytes"}, q_byte.size(), 3 * NFr);
    if (q_start.size() > 0) begin
      d = q_start[0] - t_set;
      check_eq({tag, "_latency_ok"}, (d >= 1 && d <= 4) ? 1 : 0, 1);
    end
    for (int k = 1; k < q_start.size() && k < NFr; k++)
      check_eq($sformatf("%s_start_off%0d", tag, k), q_start[k] - q_start[0], exp_start(k));
    for (int k = 0; k < q_stop.size() && k < q_start.size() && k < NFr; k++)
      check_eq($sformatf("%s_frame_len%0d", tag, k), q_stop[k] - q_start[k], 114 * Q);
    for (int f = 0; f < NFr; f++) begin
      if (q_byte.size() >= 3 * f + 3) begin
        check_eq($sformatf("%s_dev%0d", tag, f), int'(q_byte[3 * f]), 32'h42);
        check_eq($sformatf("%s_reg%0d", tag, f), int'(q_byte[3 * f + 1]), int'(exp_reg[f]));
        check_eq($sformatf("%s_val%0d", tag, f), int'(q_byte[3 * f + 2]), int'(exp_val[f]));
      end
    end
    acks = 0;
    foreach (q_ack[i]) if (q_ack[i]) acks++;
    check_eq({tag, "_ninth_released"}, acks, q_ack.size());
    check_eq({tag, "_scl_low_bad"}, n_low_bad, 0);
    check_eq({tag, "_scl_lows"}, n_lows, NFr * 28);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int bad;
    int t_set;
    int budget;
    // Reset held: start toggles must not disturb the bus.
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      start_fsm = 1'($urandom % 2);
      tick(1);
      if (scl !== 1'b1 || sda !== 1'b1) bad++;
    end
    check_eq("rst_idle_samples", bad, 0);
    check_eq("rst_no_edges", n_edges, 0);

    // Sequence A: start raised and held high throughout.
    start_fsm = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(5 + int'($urandom_range(0, 20)));
    clear_mon();
    start_fsm = 1'b1;
    t_set = cyc;
    tick(200);
    run_seq("seqA", t_set);

    // Sequence B: random start chatter while busy is ignored.
    start_fsm = 1'b0;
    tick(3 + int'($urandom_range(0, 10)));
    clear_mon();
    start_fsm = 1'b1;
    t_set = cyc;
    for (int i = 0; i < 1400; i++) begin
      tick(1);
      start_fsm = (i < 1300) ? 1'($urandom % 2) : 1'b1;
    end
    run_seq("seqB", t_set);

    // Sequence C: reset mid-entry 3, then restart from entry 0.
    start_fsm = 1'b0;
    tick(2);
    clear_mon();
    start_fsm = 1'b1;
    budget = 4 * FrameQ * Q + W + 200;
    while (q_start.size() < 4 && budget > 0) begin
      tick(1);
      budget--;
    end
    check_eq("seqC_reach_entry3", (budget > 0) ? 1 : 0, 1);
    tick(2 * Q + int'($urandom_range(4, 200)));
    reset = 1'b0;
    #1;
    check_eq("midrst_scl", int'(scl), 1);
    check_eq("midrst_sda", int'(sda), 1);
    start_fsm = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(3);
    clear_mon();
    start_fsm = 1'b1;
    t_set = cyc;
    run_seq("seqC", t_set);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
